pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_sat_cnt.sv | 25 ++
 rtl/pipe_stage_buf.sv | 158 +++++++++++++++
 tb/tb_pipe_stage_buf.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage buffer.
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CTRL_W_DEF = 16;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter; advances on the falling edge while i_inc is high.
module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage: 2-entry skid buffer (SKID=1) or 1-entry hold
// register (SKID=0), with flush, occupancy and a saturating stall counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   w_skid_ctrl;
    logic [DATA_W-1:0]   w_skid_data;
    logic                w_in_ready;
    logic                w_out_valid;
    logic [CTRL_W-1:0]   w_out_ctrl;
    logic [1:0]          w_occupancy;
    logic                w_accept;
    logic                w_drain;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    assign w_accept = in_valid && w_in_ready;
    assign w_drain  = w_out_valid && out_ready;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; flush overrides any accept or drain in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_accept) w_state_nxt = ONE;
                ONE: begin
                    if (w_accept && !w_drain) begin
                        w_state_nxt = (SKID != 0) ? FULL : ONE;
                    end else if (w_drain && !w_accept) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: if (w_drain) w_state_nxt = ONE;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    // Handshake decode and datapath load enables from the held state.
    always_comb begin
        w_out_valid      = (r_state != EMPTY);
        w_in_ready       = (SKID != 0) ? (r_state != FULL)
                                       : ((r_state == EMPTY) || out_ready);
        w_out_ctrl       = w_out_valid ? r_main_ctrl : '0;
        w_occupancy      = 2'd0;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ONE:     w_occupancy = 2'd1;
            FULL:    w_occupancy = 2'd2;
            default: w_occupancy = 2'd0;
        endcase
        if (!flush) begin
            case (r_state)
                EMPTY: w_load_main_in = w_accept;
                ONE: begin
                    w_load_main_in = w_accept && w_drain;
                    w_load_skid    = w_accept && !w_drain;
                end
                FULL:    w_load_main_skid = w_drain;
                default: ;
            endcase
        end
    end

    // Head register; flush clears control only, payload is left in place.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
        end else if (w_load_main_in) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
        end else if (w_load_main_skid) begin
            r_main_ctrl <= w_skid_ctrl;
            r_main_data <= w_skid_data;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;

            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                end else if (flush) begin
                    r_skid_ctrl <= '0;
                end else if (w_load_skid) begin
                    r_skid_ctrl <= in_ctrl;
                    r_skid_data <= in_data;
                end
            end

            assign w_skid_ctrl = r_skid_ctrl;
            assign w_skid_data = r_skid_data;
        end else begin : g_hold
            assign w_skid_ctrl = '0;
            assign w_skid_data = '0;
        end
    endgenerate

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_out_valid && !out_ready),
        .o_cnt (stall_cnt)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_ctrl  = w_out_ctrl;
    assign out_data  = r_main_data;
    assign occupancy = w_occupancy;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: SKID=1 and SKID=0 instances driven in parallel,
// checked each cycle against a queue model plus literal expectations.
module tb_pipe_stage_buf;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam int unsigned NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [CW-1:0] a_out_ctrl, b_out_ctrl;
    logic [DW-1:0] a_out_data, b_out_data;
    logic [1:0]    a_occ, b_occ;
    logic [NW-1:0] a_stall, b_stall;

    int errors = 0;
    int checks = 0;

    // Model: per instance, an ordered list of held entries (at most 2).
    int            n      [2];
    logic [CW-1:0] mc     [2][2];
    logic [DW-1:0] md     [2][2];
    logic [DW-1:0] last_d [2];
    int            sc     [2];
    logic [DW-1:0] log_a  [$];
    int            b_max = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
        .out_data(a_out_data), .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .occupancy(b_occ), .stall_cnt(b_stall)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic exp_ready(input int k);
        if (k == 0) return n[0] < 2;
        return (n[1] == 0) || out_ready;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            n[k]      = 0;
            last_d[k] = '0;
            sc[k]     = 0;
        end
    endtask

    task automatic model_advance();
        for (int k = 0; k < 2; k++) begin
            logic acc, drn;
            acc = in_valid && exp_ready(k);
            drn = (n[k] > 0) && out_ready;
            if ((n[k] > 0) && !out_ready && (sc[k] < 15)) sc[k]++;
            if (flush) begin
                n[k] = 0;
            end else begin
                if (drn) begin
                    if (k == 0) log_a.push_back(md[k][0]);
                    md[k][0] = md[k][1];
                    mc[k][0] = mc[k][1];
                    n[k]--;
                end
                if (acc && n[k] < 2) begin
                    md[k][n[k]] = in_data;
                    mc[k][n[k]] = in_ctrl;
                    n[k]++;
                end
            end
            if (n[k] > 0) last_d[k] = md[k][0];
        end
    endtask

    // Mid-cycle compare against the model, then advance it with the inputs
    // that the coming falling edge will sample.
    always @(posedge clk) begin
        if (rst) model_reset();
        for (int k = 0; k < 2; k++) begin
            logic          gv, gr;
            logic [CW-1:0] gc, ec;
            logic [DW-1:0] gd, ed;
            logic [1:0]    go;
            logic [NW-1:0] gs;
            gv = (k == 0) ? a_out_valid : b_out_valid;
            gr = (k == 0) ? a_in_ready  : b_in_ready;
            gc = (k == 0) ? a_out_ctrl  : b_out_ctrl;
            gd = (k == 0) ? a_out_data  : b_out_data;
            go = (k == 0) ? a_occ       : b_occ;
            gs = (k == 0) ? a_stall     : b_stall;
            ec = (n[k] > 0) ? mc[k][0] : '0;
            ed = (n[k] > 0) ? md[k][0] : last_d[k];
            chk($sformatf("m%0d_out_valid", k), 32'(gv), 32'(n[k] > 0));
            chk($sformatf("m%0d_in_ready", k),  32'(gr), 32'(exp_ready(k)));
            chk($sformatf("m%0d_out_ctrl", k),  32'(gc), 32'(ec));
            chk($sformatf("m%0d_out_data", k),  32'(gd), 32'(ed));
            chk($sformatf("m%0d_occupancy", k), 32'(go), 32'(n[k]));
            chk($sformatf("m%0d_stall_cnt", k), 32'(gs), 32'(sc[k]));
        end
        if (int'(b_occ) > b_max) b_max = int'(b_occ);
        if (!rst) model_advance();
    end

    task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic fl);
        @(negedge clk);
        #1;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        logic [DW-1:0] exp_log [12];
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        #3;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data",  32'(a_out_data),  32'd0);
        chk("rst_occupancy", 32'(a_occ),       32'd0);
        chk("rst_in_ready",  32'(a_in_ready),  32'd1);

        // Streaming at full rate
        step(1'b1, 16'h0001, 32'hA0, 1'b1, 1'b0);
        rst = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 16'h0001, 32'(32'hA0 + i), 1'b1, 1'b0);
            chk("stream_valid", 32'(a_out_valid), 32'd1);
            chk("stream_data",  32'(a_out_data),  32'(32'hA0 + i - 1));
            if (i == 1) chk("skid0_ready_one", 32'(b_in_ready), 32'd1);
        end
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);

        // Backpressure fills the skid buffer, B2 waits upstream
        step(1'b1, 16'h0001, 32'hB0, 1'b0, 1'b0);
        step(1'b1, 16'h0001, 32'hB1, 1'b0, 1'b0);
        step(1'b1, 16'h0001, 32'hB2, 1'b0, 1'b0);
        chk("bp_occupancy", 32'(a_occ),      32'd2);
        chk("bp_in_ready",  32'(a_in_ready), 32'd0);
        step(1'b1, 16'h0001, 32'hB2, 1'b0, 1'b0);
        step(1'b1, 16'h0001, 32'hB2, 1'b1, 1'b0);
        chk("bp_stall_cnt", 32'(a_stall), 32'd3);
        chk("bp_head",      32'(a_out_data), 32'hB0);
        step(1'b1, 16'h0001, 32'hB2, 1'b1, 1'b0);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);

        // Flush while full, then flush in ONE with a simultaneous accept and drain
        step(1'b1, 16'h0002, 32'h11, 1'b0, 1'b0);
        step(1'b1, 16'h0002, 32'h12, 1'b0, 1'b0);
        step(1'b1, 16'h0001, 32'hC0, 1'b0, 1'b1);
        chk("fl_full_occ", 32'(a_occ), 32'd2);
        step(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
        chk("fl_out_valid", 32'(a_out_valid), 32'd0);
        chk("fl_out_ctrl",  32'(a_out_ctrl),  32'd0);
        chk("fl_out_data",  32'(a_out_data),  32'h11);
        step(1'b1, 16'h0002, 32'h13, 1'b0, 1'b0);
        step(1'b1, 16'h0003, 32'hC1, 1'b1, 1'b1);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
        chk("fl2_occupancy", 32'(a_occ),      32'd0);
        chk("fl2_out_data",  32'(a_out_data), 32'h13);

        // Stall counter saturation
        step(1'b1, 16'h0004, 32'hE0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
        chk("sat_stall_cnt", 32'(a_stall), 32'd15);
        chk("sat_valid",     32'(a_out_valid), 32'd1);

        // Asynchronous reset while full and draining
        step(1'b1, 16'h0004, 32'hE1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
        chk("pre_rst_occ", 32'(a_occ), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(a_out_valid), 32'd0);
        chk("arst_out_ctrl",  32'(a_out_ctrl),  32'd0);
        chk("arst_out_data",  32'(a_out_data),  32'd0);
        chk("arst_occupancy", 32'(a_occ),       32'd0);
        chk("arst_in_ready",  32'(a_in_ready),  32'd1);
        chk("arst_stall_cnt", 32'(a_stall),     32'd0);
        step(1'b1, 16'h0005, 32'hD0, 1'b1, 1'b0);
        rst = 1'b0;
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
        chk("post_rst_valid", 32'(a_out_valid), 32'd1);
        chk("post_rst_data",  32'(a_out_data),  32'hD0);
        step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);

        // Drain order for the skid instance over the whole run
        for (int i = 0; i < 8; i++) exp_log[i] = 32'(32'hA0 + i);
        exp_log[8]  = 32'hB0;
        exp_log[9]  = 32'hB1;
        exp_log[10] = 32'hB2;
        exp_log[11] = 32'hD0;
        chk("drain_count", 32'(log_a.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < log_a.size()) chk($sformatf("drain_%0d", i), log_a[i], exp_log[i]);
        end
        chk("skid0_max_occ", 32'(b_max), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
